// File: rtl/lcd_text_pkg.sv
// Shared constants and state encoding for the LCD text writer.
package lcd_text_pkg;

   // Text geometry and blank character
   localparam int         COLS = 16;
   localparam int         ROWS = 4;
   localparam logic [7:0] FILL = 8'h20;

   // Control codes recognised by the writer
   localparam logic [7:0] CC_BS = 8'h08;
   localparam logic [7:0] CC_LF = 8'h0A;
   localparam logic [7:0] CC_FF = 8'h0C;
   localparam logic [7:0] CC_CR = 8'h0D;

   typedef enum logic [1:0] {
      ST_CLEAR   = 2'd0,
      ST_IDLE    = 2'd1,
      ST_ROW_CLR = 2'd2
   } state_t;

   // Everything from 0x20 up is a glyph (ASCII plus ST7920 CGROM codes)
   function automatic logic is_printable(input logic [7:0] b);
      return (b >= 8'h20);
   endfunction

endpackage

// File: rtl/lcd_text_writer.sv
// Character-stream front end: decodes bytes, tracks a row/col cursor and
// drives the write port of the 64-byte display RAM.
module lcd_text_writer #(
   parameter int         COLS = lcd_text_pkg::COLS,
   parameter int         ROWS = lcd_text_pkg::ROWS,
   parameter logic [7:0] FILL = lcd_text_pkg::FILL
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       we,
   output logic [5:0] write_address,
   output logic [7:0] wr_data,
   output logic [5:0] cursor,
   output logic       busy
);
   import lcd_text_pkg::*;

   localparam int COL_W    = $clog2(COLS);
   localparam int ROW_W    = $clog2(ROWS);
   localparam int LAST_IDX = COLS * ROWS - 1;

   state_t           state, state_n;
   logic [5:0]       idx, idx_n;     // shared clear index; low COL_W bits = column in ROW_CLR
   logic             last, last_n;   // final clear write was issued last cycle
   logic [ROW_W-1:0] row, row_n;
   logic [COL_W-1:0] col, col_n;
   logic             we_n;
   logic [5:0]       addr_n;
   logic [7:0]       data_n;
   logic             accept;

   assign in_ready = (state == ST_IDLE);
   assign busy     = (state != ST_IDLE);
   assign cursor   = {row, col};
   assign accept   = in_valid && in_ready;

   // Next-state, cursor and write-port decode
   always_comb begin
      state_n = state;
      idx_n   = idx;
      last_n  = 1'b0;
      row_n   = row;
      col_n   = col;
      we_n    = 1'b0;
      addr_n  = write_address;
      data_n  = wr_data;

      case (state)
         ST_CLEAR: begin
            // Extra cycle after the last write so in_ready rises after it
            if (last) begin
               state_n = ST_IDLE;
               idx_n   = '0;
               row_n   = '0;
               col_n   = '0;
            end else begin
               we_n   = 1'b1;
               addr_n = idx;
               data_n = FILL;
               idx_n  = idx + 6'd1;
               last_n = (idx == 6'(LAST_IDX));
            end
         end

         ST_ROW_CLR: begin
            if (last) begin
               state_n = ST_IDLE;
               idx_n   = '0;
            end else begin
               we_n   = 1'b1;
               addr_n = {row, idx[COL_W-1:0]};
               data_n = FILL;
               idx_n  = idx + 6'd1;
               last_n = &idx[COL_W-1:0];
            end
         end

         ST_IDLE: begin
            if (accept) begin
               if (is_printable(in_data)) begin
                  we_n   = 1'b1;
                  addr_n = {row, col};
                  data_n = in_data;
                  col_n  = col + COL_W'(1);
                  // Auto-wrap: move to the next row and blank it
                  if (&col) begin
                     row_n   = row + ROW_W'(1);
                     state_n = ST_ROW_CLR;
                     idx_n   = '0;
                  end
               end else begin
                  case (in_data)
                     CC_CR: col_n = '0;
                     CC_LF: begin
                        col_n   = '0;
                        row_n   = row + ROW_W'(1);
                        state_n = ST_ROW_CLR;
                        idx_n   = '0;
                     end
                     CC_BS: begin
                        // Never crosses back into the previous row
                        if (col != '0) begin
                           col_n  = col - COL_W'(1);
                           we_n   = 1'b1;
                           addr_n = {row, col - COL_W'(1)};
                           data_n = FILL;
                        end
                     end
                     CC_FF: begin
                        state_n = ST_CLEAR;
                        idx_n   = '0;
                     end
                     default: ;  // other control codes are swallowed
                  endcase
               end
            end
         end

         default: begin
            state_n = ST_CLEAR;
            idx_n   = '0;
         end
      endcase
   end

   // FSM state and shared clear index
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_CLEAR;
         idx   <= '0;
         last  <= 1'b0;
      end else begin
         state <= state_n;
         idx   <= idx_n;
         last  <= last_n;
      end
   end

   // Cursor and registered RAM write port
   always_ff @(posedge clk) begin
      if (rst) begin
         row           <= '0;
         col           <= '0;
         we            <= 1'b0;
         write_address <= '0;
         wr_data       <= FILL;
      end else begin
         row           <= row_n;
         col           <= col_n;
         we            <= we_n;
         write_address <= addr_n;
         wr_data       <= data_n;
      end
   end

endmodule

// File: tb/tb_lcd_text_writer.sv
// Directed bench for lcd_text_writer.
module tb_lcd_text_writer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_ready, we, busy;
   logic [5:0] write_address, cursor;
   logic [7:0] wr_data;

   int n_vec = 0;
   int n_err = 0;

   lcd_text_writer dut (
      .clk          (clk),
      .rst          (rst),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .we           (we),
      .write_address(write_address),
      .wr_data      (wr_data),
      .cursor       (cursor),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected write port as {we, address, data}
   function automatic logic [31:0] wr(input int a, input logic [7:0] d);
      return {17'd0, 1'b1, 6'(a), d};
   endfunction

   function automatic logic [31:0] port();
      return {17'd0, we, write_address, wr_data};
   endfunction

   task automatic send(input logic [7:0] b);
      in_valid = 1'b1;
      in_data  = b;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic expect_reset();
      chk("rst_we",    we, 0);
      chk("rst_addr",  write_address, 0);
      chk("rst_data",  wr_data, 8'h20);
      chk("rst_ready", in_ready, 0);
      chk("rst_busy",  busy, 1);
      chk("rst_cur",   cursor, 0);
   endtask

   task automatic expect_full_clear();
      for (int k = 0; k < 64; k++) begin
         tick();
         chk("clr_wr", port(), wr(k, 8'h20));
         chk("clr_rdy", in_ready, 0);
      end
      tick();
      chk("clr_done_rdy",  in_ready, 1);
      chk("clr_done_busy", busy, 0);
      chk("clr_done_we",   we, 0);
      chk("clr_done_cur",  cursor, 0);
   endtask

   task automatic expect_row_clr(input int base);
      for (int j = 0; j < 16; j++) begin
         tick();
         chk("rowclr_wr", port(), wr(base + j, 8'h20));
         chk("rowclr_rdy", in_ready, 0);
      end
      tick();
      chk("rowclr_done_rdy", in_ready, 1);
      chk("rowclr_done_we",  we, 0);
      chk("rowclr_done_cur", cursor, base);
   endtask

   initial begin
      // Reset values
      tick();
      tick();
      expect_reset();

      // Power-up clear: 64 writes then ready
      rst = 1'b0;
      expect_full_clear();

      // "AB" back to back
      in_valid = 1'b1;
      in_data  = 8'h41;
      tick();
      chk("A_wr", port(), wr(0, 8'h41));
      chk("A_cur", cursor, 1);
      chk("A_rdy", in_ready, 1);
      in_data = 8'h42;
      tick();
      chk("B_wr", port(), wr(1, 8'h42));
      chk("B_cur", cursor, 2);
      in_valid = 1'b0;
      tick();
      chk("AB_idle_we", we, 0);

      // CR back to column 0
      send(8'h0D);
      chk("cr_we", we, 0);
      chk("cr_cur", cursor, 0);
      chk("cr_rdy", in_ready, 1);

      // 16 characters fill row 0, wrap blanks row 1
      in_valid = 1'b1;
      in_data  = 8'h41;
      for (int i = 0; i < 16; i++) begin
         tick();
         chk("a16_wr", port(), wr(i, 8'h41));
         chk("a16_rdy", in_ready, (i < 15) ? 1 : 0);
      end
      in_valid = 1'b0;
      chk("a16_busy", busy, 1);
      expect_row_clr(16);

      // LF twice to reach row 3, then LF wraps to row 0
      send(8'h0A);
      chk("lf1_we", we, 0);
      chk("lf1_rdy", in_ready, 0);
      expect_row_clr(32);
      send(8'h0A);
      expect_row_clr(48);
      send(8'h0A);
      chk("lf3_we", we, 0);
      expect_row_clr(0);

      // CR at column 5
      for (int i = 0; i < 5; i++) begin
         send(8'h78);
         chk("x_wr", port(), wr(i, 8'h78));
      end
      chk("col5_cur", cursor, 5);
      send(8'h0D);
      chk("cr5_we", we, 0);
      chk("cr5_cur", cursor, 0);

      // BS at cursor 3
      send(8'h61);
      send(8'h62);
      send(8'h63);
      chk("abc_cur", cursor, 3);
      send(8'h08);
      chk("bs3_wr", port(), wr(2, 8'h20));
      chk("bs3_cur", cursor, 2);
      chk("bs3_rdy", in_ready, 1);

      // Fill to end of row 0 from col 2, wrap to cursor 16
      for (int i = 0; i < 14; i++) begin
         send(8'h30 + 8'(i));
         chk("fill_wr", port(), wr(2 + i, 8'h30 + 8'(i)));
      end
      chk("fill_wrap_rdy", in_ready, 0);
      expect_row_clr(16);

      // BS at column 0 does nothing
      send(8'h08);
      chk("bs16_we", we, 0);
      chk("bs16_cur", cursor, 16);
      chk("bs16_rdy", in_ready, 1);

      // Ignored control code
      send(8'h07);
      chk("bel_we", we, 0);
      chk("bel_rdy", in_ready, 1);
      chk("bel_cur", cursor, 16);

      // High CGROM code is printable
      send(8'hA5);
      chk("cg_wr", port(), wr(16, 8'hA5));
      chk("cg_cur", cursor, 17);

      // FF, aborted by reset at clear index 20
      send(8'h0C);
      chk("ff_we", we, 0);
      chk("ff_rdy", in_ready, 0);
      chk("ff_busy", busy, 1);
      for (int k = 0; k < 20; k++) begin
         tick();
         chk("ff_wr", port(), wr(k, 8'h20));
      end
      rst = 1'b1;
      tick();
      expect_reset();
      rst = 1'b0;
      expect_full_clear();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/lcd_text_writer.md
# lcd_text_writer

Character-stream front end for the 128x64 ST7920 text display. Accepts one byte per valid/ready handshake, interprets a small set of control codes, tracks a row/column cursor, and writes glyph codes into the 64-byte display RAM. The LCD12864 driver scans that RAM on the read port. This block owns the write port (`we`, `write_address`, `wr_data`) and replaces the free-running test writer in `lcd_top`.

## Interface
Parameters:
- `COLS`, default 16: characters per row.
- `ROWS`, default 4: text rows. `COLS*ROWS` must equal 64.
- `FILL`, default 8'h20: blank character written by clears.

Ports:
- `clk`, in, 1: system clock (50 MHz).
- `rst`, in, 1: reset, synchronous, active-high.
- `in_data`, in, 8: character or control byte.
- `in_valid`, in, 1: `in_data` is valid.
- `in_ready`, out, 1: block can accept a byte.
- `we`, out, 1: RAM write enable.
- `write_address`, out, 6: RAM write address, equal to row*COLS+col.
- `wr_data`, out, 8: RAM write data.
- `cursor`, out, 6: current linear cursor position.
- `busy`, out, 1: a clear sequence is in progress.

## Operation
- A byte is accepted when `in_valid && in_ready`. `in_ready` is high only in IDLE.
- States: CLEAR, IDLE, ROW_CLR.
  - CLEAR writes `FILL` to addresses 0..63, then sets the cursor to 0 and goes to IDLE.
  - ROW_CLR writes `FILL` to the 16 addresses of the current row, then goes to IDLE.
- Byte decode in IDLE:
  - 0x20..0xFF (printable, and ST7920 CGROM codes): write the byte at the cursor, then set col+1. If col was 15, set col=0, row=(row+1) mod 4, and go to ROW_CLR.
  - 0x0D (CR): col=0. No write.
  - 0x0A (LF): col=0, row=(row+1) mod 4, then ROW_CLR. Row 3 wraps to row 0. There is no scrolling.
  - 0x08 (BS): if col>0, set col-1 and write `FILL` there. If col=0, no-op; BS never crosses rows.
  - 0x0C (FF): go to CLEAR.
  - Any other byte in 0x00..0x1F: consumed and ignored.
- Arithmetic rules:
  - col is 4-bit and row is 2-bit. Wrap is natural modulo.
  - `cursor` = {row, col}.
- The RAM is linear. Mapping rows to ST7920 DDRAM order (0,2,1,3) is the driver's job.

## Timing
- Values while `rst` is high:
  - state = CLEAR with index 0.
  - `we`=0, `write_address`=0, `wr_data`=`FILL`, `in_ready`=0, `busy`=1, `cursor`=0.
- Reset release and power-up clear:
  - First cycle after `rst` falls: `we`=1, address 0.
  - Last clear write: address 63, 64 cycles after release.
  - Next cycle: `in_ready`=1 and `busy`=0.
- Write latency: a printable byte accepted at edge N drives `we`=1 with the registered address and data in cycle N+1. `cursor` updates at the same edge.
- Non-writing controls (CR, ignored codes, BS at col 0): no `we` pulse. `in_ready` stays high, so one byte per cycle is sustainable.
- Auto-wrap and LF:
  - `in_ready` drops the cycle after acceptance.
  - For a printable at col 15: 1 character write plus 16 ROW_CLR writes.
  - For LF: 16 ROW_CLR writes.
  - `in_ready` rises the cycle after the last write.
- FF: 64 writes with `in_ready` low, then `cursor`=0.
- `busy` is high in CLEAR and ROW_CLR only.
- `we` is a single-cycle pulse per write and is never asserted in IDLE without an accepted write.
- `rst` asserted mid-sequence aborts it. The full CLEAR restarts after release.

## Structure
- Shared package `lcd_text_pkg`:
  - Control-code constants: `CC_BS`, `CC_LF`, `CC_FF`, `CC_CR`.
  - `COLS`, `ROWS`, `FILL`.
  - The state encoding (CLEAR, IDLE, ROW_CLR).
- Single module, no sub-module.
- One 6-bit clear index counter is shared by CLEAR and ROW_CLR; in ROW_CLR its low 4 bits are the column.
- RAM and LCD12864 stay instantiated in `lcd_top`. This block connects to the RAM write side.

## Test plan
- Reset release: expect 64 consecutive `we` pulses, addresses 0..63 with data 0x20, then `in_ready`=1 at cycle 65 and `cursor`=0.
- Send "AB": expect writes (0,0x41) and (1,0x42), then `cursor`=2. Back-to-back valid gives no stall.
- Send 16 x 0x41 starting at cursor 0: expect writes to addresses 0..15, then 16 `FILL` writes to 16..31, `in_ready` low for 17 cycles, final `cursor`=16.
- Cursor at 48, send LF: expect `FILL` written to 0..15 and `cursor`=0. Then CR at col 5 gives `cursor` col 0 with no write.
- BS sequence:
  - At `cursor`=3: expect write (2,0x20) and `cursor`=2.
  - At `cursor`=16: no write, `cursor` unchanged.
  - 0x07: ignored, `in_ready` stays high.
- FF mid-text, then `rst` pulsed at clear index 20: expect the sequence to abort and a full 64-write clear to restart after release.
